// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Round-robin arbiter that shares one pixel-memory port (AW-bit address,
// DW-bit data, 1-cycle read latency) between two filter engines. The
// arbiter grants whole bursts and caps each grant at BURST_MAX beats so one
// engine cannot starve the other. Read data is steered back to whichever
// requester issued the read beat, even across a grant switch.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset (0 = in reset)
//   req0/req1           requester n wants the port, held for the burst
//   wen0/wen1           beat type: 1 = write, 0 = read
//   addr0/addr1         beat address
//   wdata0/wdata1       beat write data
//   ack0/ack1           beat accepted this cycle (combinational)
//   rvalid0/rvalid1     read data on rdata belongs to requester n
//   rdata               shared read-data bus (pass-through of mem_rdata)
//   mem_addr/mem_wen/mem_wdata  memory command side
//   mem_rdata           memory read data, valid 1 cycle after a read beat
//
// Optional feature
//   ARB_STATS_EN : adds gnt_cnt0/gnt_cnt1 (grants per requester, including
//                  burst-cap regrants) and conflict_cnt (cycles where the
//                  non-owner is requesting). All 16-bit and saturating.
//                  Arbitration is identical with or without it.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW        = 14,
    parameter int DW        = 8,
    parameter int BURST_MAX = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          wen0,
    input  logic          wen1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   gnt_cnt0,
    output logic [15:0]   gnt_cnt1,
    output logic [15:0]   conflict_cnt
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    // Beat index of the last beat a single grant may carry.
    localparam logic [7:0] CAP_LAST = 8'(BURST_MAX - 1);

    logic [1:0] state_q,      state_d;
    logic       last_owner_q, last_owner_d;
    logic [7:0] beat_cnt_q,   beat_cnt_d;
    logic [1:0] rd_tag_q,     rd_tag_d;

    // Beat acceptance and memory command mux for the current owner.
    always_comb begin
        ack0      = (state_q == ST_GNT0) && req0;
        ack1      = (state_q == ST_GNT1) && req1;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        mem_wen   = 1'b0;
        if (ack0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_wen   = wen0;
        end else if (ack1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_wen   = wen1;
        end else begin
            mem_addr  = {AW{1'b0}};
            mem_wdata = {DW{1'b0}};
            mem_wen   = 1'b0;
        end
    end

    // Read-return tagging: remember which requester issued this cycle's read
    // so the data arriving next cycle is routed to it regardless of grant.
    always_comb begin
        rd_tag_d = {ack1 && !wen1, ack0 && !wen0};
        rvalid0  = rd_tag_q[0];
        rvalid1  = rd_tag_q[1];
        rdata    = mem_rdata;
    end

    // Arbitration FSM next-state. Any exit from a grant (release or burst
    // cap) records the owner so the next tie goes the other way.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                beat_cnt_d = 8'd0;
                if (req0 && req1) begin
                    state_d = last_owner_q ? ST_GNT0 : ST_GNT1;
                end else if (req0) begin
                    state_d = ST_GNT0;
                end else if (req1) begin
                    state_d = ST_GNT1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (!req0) begin
                    last_owner_d = 1'b0;
                    beat_cnt_d   = 8'd0;
                    state_d      = req1 ? ST_GNT1 : ST_IDLE;
                end else if (beat_cnt_q == CAP_LAST) begin
                    // Cap reached: hand over if the other side waits,
                    // otherwise start a fresh burst without a bubble.
                    last_owner_d = 1'b0;
                    beat_cnt_d   = 8'd0;
                    state_d      = req1 ? ST_GNT1 : ST_GNT0;
                end else begin
                    beat_cnt_d   = beat_cnt_q + 8'd1;
                end
            end
            ST_GNT1: begin
                if (!req1) begin
                    last_owner_d = 1'b1;
                    beat_cnt_d   = 8'd0;
                    state_d      = req0 ? ST_GNT0 : ST_IDLE;
                end else if (beat_cnt_q == CAP_LAST) begin
                    last_owner_d = 1'b1;
                    beat_cnt_d   = 8'd0;
                    state_d      = req0 ? ST_GNT0 : ST_GNT1;
                end else begin
                    beat_cnt_d   = beat_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = 8'd0;
            end
        endcase
    end

    // FSM and read-tag registers; reset drops any in-flight read return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            beat_cnt_q   <= 8'd0;
            rd_tag_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            rd_tag_q     <= rd_tag_d;
        end
    end

`ifdef ARB_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    logic        enter_gnt0_s;
    logic        enter_gnt1_s;
    logic        conflict_s;
    logic [15:0] gnt_cnt0_q,     gnt_cnt0_d;
    logic [15:0] gnt_cnt1_q,     gnt_cnt1_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    // Grant entry detection: a change of owner, or a burst-cap regrant to
    // the same owner (staying in GNTn while the cap beat is taken).
    always_comb begin
        enter_gnt0_s   = (state_d == ST_GNT0) &&
                         ((state_q != ST_GNT0) || (beat_cnt_q == CAP_LAST));
        enter_gnt1_s   = (state_d == ST_GNT1) &&
                         ((state_q != ST_GNT1) || (beat_cnt_q == CAP_LAST));
        conflict_s     = ((state_q == ST_GNT0) && req1) ||
                         ((state_q == ST_GNT1) && req0);
        gnt_cnt0_d     = enter_gnt0_s ? sat_inc16(gnt_cnt0_q) : gnt_cnt0_q;
        gnt_cnt1_d     = enter_gnt1_s ? sat_inc16(gnt_cnt1_q) : gnt_cnt1_q;
        conflict_cnt_d = conflict_s ? sat_inc16(conflict_cnt_q) : conflict_cnt_q;
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_cnt0_q     <= 16'd0;
            gnt_cnt1_q     <= 16'd0;
            conflict_cnt_q <= 16'd0;
        end else begin
            gnt_cnt0_q     <= gnt_cnt0_d;
            gnt_cnt1_q     <= gnt_cnt1_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign gnt_cnt0     = gnt_cnt0_q;
    assign gnt_cnt1     = gnt_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. The main process drives requester
// behaviour and pushes the expected accepted beats and read returns into
// queues; a separate monitor pops and compares whenever the DUT acks a beat
// or raises an rvalid. A small memory model returns addr[7:0] + 8'h10.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
    } ack_e;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } rd_e;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, wen0, wen1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = 8'h00;
`ifdef ARB_STATS_EN
    logic [15:0]   gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   left0, left1;
    logic s_ack1, s_rv0;
    logic [DW-1:0] s_rdata;

    ack_e exp_ack[$];
    rd_e  exp_rd[$];

    mem_port_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wen0(wen0), .wen1(wen1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: 1-cycle read latency, contents = low address byte + 0x10.
    always @(posedge clk) mem_rdata <= mem_addr[7:0] + 8'h10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_ack(input int p, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        ack_e e;
        e.port = p; e.addr = a; e.wen = w; e.wdata = d;
        exp_ack.push_back(e);
    endtask

    task automatic push_rd(input int p, input logic [DW-1:0] d);
        rd_e e;
        e.port = p; e.data = d;
        exp_rd.push_back(e);
    endtask

    // One clock of requester behaviour: sample acks on the falling edge,
    // advance to the next beat just after the rising edge that took it.
    task automatic cycle();
        logic g0, g1;
        @(negedge clk);
        g0 = ack0; g1 = ack1;
        s_ack1 = ack1; s_rv0 = rvalid0; s_rdata = rdata;
        @(posedge clk);
        #1;
        if (g0) begin
            addr0 = addr0 + 14'd1;
            wdata0 = addr0[7:0] ^ 8'h5A;
            if (left0 > 0) begin
                left0--;
                if (left0 == 0) req0 = 1'b0;
            end
        end
        if (g1) begin
            addr1 = addr1 + 14'd1;
            wdata1 = addr1[7:0] ^ 8'hC3;
            if (left1 > 0) begin
                left1--;
                if (left1 == 0) req1 = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set0(input logic [AW-1:0] base, input logic w, input int n);
        addr0 = base; wdata0 = base[7:0] ^ 8'h5A; wen0 = w; left0 = n; req0 = 1'b1;
    endtask

    task automatic set1(input logic [AW-1:0] base, input logic w, input int n);
        addr1 = base; wdata1 = base[7:0] ^ 8'hC3; wen1 = w; left1 = n; req1 = 1'b1;
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0; left0 = 0; left1 = 0;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_ackq_empty"}, exp_ack.size(), 0);
        check({tag, "_rdq_empty"}, exp_rd.size(), 0);
        exp_ack.delete();
        exp_rd.delete();
    endtask

    // Monitor: compares every accepted beat and every read return against
    // the queues, and checks read-return latency against last cycle's reads.
    initial begin
        logic pend0, pend1;
        ack_e ea;
        rd_e  er;
        pend0 = 1'b0; pend1 = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                check("rvalid0_latency", rvalid0, pend0);
                check("rvalid1_latency", rvalid1, pend1);
                if (rvalid0 || rvalid1) begin
                    if (exp_rd.size() == 0) begin
                        check("rd_unexpected", {rvalid1, rvalid0}, 0);
                    end else begin
                        er = exp_rd.pop_front();
                        check("rd_port", rvalid1 ? 1 : 0, er.port);
                        check("rd_both", rvalid0 && rvalid1, 0);
                        check("rd_data", rdata, er.data);
                    end
                end
                if (ack0 || ack1) begin
                    if (exp_ack.size() == 0) begin
                        check("ack_unexpected", {ack1, ack0}, 0);
                    end else begin
                        ea = exp_ack.pop_front();
                        check("ack_port", ack1 ? 1 : 0, ea.port);
                        check("ack_both", ack0 && ack1, 0);
                        check("mem_addr", mem_addr, ea.addr);
                        check("mem_wen", mem_wen, ea.wen);
                        if (ea.wen) check("mem_wdata", mem_wdata, ea.wdata);
                    end
                end else begin
                    check("idle_mem_wen", mem_wen, 0);
                    check("idle_mem_addr", mem_addr, 0);
                end
                pend0 = ack0 && !wen0;
                pend1 = ack1 && !wen1;
            end else begin
                pend0 = 1'b0;
                pend1 = 1'b0;
            end
        end
    end

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
        addr0 = 14'h0; addr1 = 14'h0; wdata0 = 8'h00; wdata1 = 8'h00;
        left0 = 0; left1 = 0;
        s_ack1 = 1'b0; s_rv0 = 1'b0; s_rdata = 8'h00;

        // Reset held with req0 high, then a 4-beat read burst from addr 0.
        set0(14'h0, 1'b0, 4);
        run(2);
        check("rst_ack0", ack0, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_rvalid0", rvalid0, 0);
        for (int k = 0; k < 4; k++) begin
            push_ack(0, 14'(k), 1'b0, 8'h00);
            push_rd(0, 8'(8'h10 + k));
        end
        reset = 1'b1;
        #1;
        check("release_ack0_idle", ack0, 0);
        cycle();
        check("first_ack0_after_grant", ack0, 1);
        run(8);
        check_empty("read_burst");

        // Ties: first tie after reset goes to 0, then to 1 once 0 owned last.
        do_reset();
        set0(14'h100, 1'b1, 1);
        set1(14'h200, 1'b1, 1);
        push_ack(0, 14'h100, 1'b1, 8'h5A);
        push_ack(1, 14'h200, 1'b1, 8'hC3);
        run(8);
        set0(14'h110, 1'b1, 1);
        push_ack(0, 14'h110, 1'b1, 8'h4A);
        run(4);
        set0(14'h120, 1'b1, 1);
        set1(14'h220, 1'b1, 1);
        push_ack(1, 14'h220, 1'b1, 8'hE3);
        push_ack(0, 14'h120, 1'b1, 8'h7A);
        run(8);
        check_empty("tie");

        // Burst cap: both held -> 16/16/16/16 with no idle cycles in the window.
        do_reset();
        set0(14'h100, 1'b1, 1000);
        set1(14'h200, 1'b1, 1000);
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 16; j++) begin
                logic [AW-1:0] a;
                if ((b % 2) == 0) begin
                    a = 14'(14'h100 + (b / 2) * 16 + j);
                    push_ack(0, a, 1'b1, a[7:0] ^ 8'h5A);
                end else begin
                    a = 14'(14'h200 + (b / 2) * 16 + j);
                    push_ack(1, a, 1'b1, a[7:0] ^ 8'hC3);
                end
            end
        end
        run(65);
        req0 = 1'b0; req1 = 1'b0; left0 = 0; left1 = 0;
        run(3);
        check_empty("cap_alt");
        // Only req0: regranted at the cap with continuous acks.
        set0(14'h140, 1'b1, 40);
        for (int k = 0; k < 40; k++) begin
            logic [AW-1:0] a;
            a = 14'(14'h140 + k);
            push_ack(0, a, 1'b1, a[7:0] ^ 8'h5A);
        end
        run(41);
        run(3);
        check_empty("cap_solo");

        // Grant switch at the cap with the last read (addr 127) in flight.
        do_reset();
        set0(14'd112, 1'b0, 16);
        set1(14'h200, 1'b0, 2);
        for (int k = 0; k < 16; k++) begin
            push_ack(0, 14'(112 + k), 1'b0, 8'h00);
            push_rd(0, 8'(8'h80 + k));
        end
        push_ack(1, 14'h200, 1'b0, 8'h00);
        push_ack(1, 14'h201, 1'b0, 8'h00);
        push_rd(1, 8'h10);
        push_rd(1, 8'h11);
        run(17);
        cycle();
        check("switch_ack1", s_ack1, 1);
        check("switch_rvalid0", s_rv0, 1);
        check("switch_rdata", s_rdata, 8'h8F);
        run(6);
        check_empty("switch");

        // Reset pulsed while beat 6 of a write burst is presented.
        do_reset();
        set0(14'h300, 1'b1, 10);
        for (int k = 0; k < 5; k++) begin
            logic [AW-1:0] a;
            a = 14'(14'h300 + k);
            push_ack(0, a, 1'b1, a[7:0] ^ 8'h5A);
        end
        run(6);
        check("pre_reset_ack0", ack0, 1);
`ifdef ARB_STATS_EN
        check("pre_reset_gnt_cnt0", gnt_cnt0, 1);
`endif
        reset = 1'b0;
        #1;
        check("midrst_mem_wen", mem_wen, 0);
        check("midrst_ack0", ack0, 0);
`ifdef ARB_STATS_EN
        check("midrst_gnt_cnt0", gnt_cnt0, 0);
        check("midrst_gnt_cnt1", gnt_cnt1, 0);
        check("midrst_conflict", conflict_cnt, 0);
`endif
        req0 = 1'b0; left0 = 0;
        cycle();
        reset = 1'b1;
        run(4);
        check_empty("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
